flog_special_result_encoder: RTL

Output-side counterpart of the bfloat16 FLOG special-case detector: consumes the operand classification flags plus the normal-path log result, encodes the final bfloat16 result and IEEE exception flags, and delivers them through a registered valid/ready output stage with a 2-entry skid buffer. Sits at the tail of the FLOG unit, between the log datapath and the writeback/result bus.

---
 rtl/flog_pkg.sv | 54 +++++
 rtl/flog_result_mux.sv | 39 +++
 rtl/flog_special_result_encoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/flog_pkg.sv
// Shared constants, flag indices and result payload for the bfloat16 FLOG unit.
package flog_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 7;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned RES_W  = 1 + EXP_W + MAN_W;

  localparam logic [RES_W-1:0] QNAN       = RES_W'(16'h7fc0);
  localparam logic [RES_W-1:0] PLUS_INF   = RES_W'(16'h7f80);
  localparam logic [RES_W-1:0] MINUS_INF  = RES_W'(16'hff80);
  localparam logic [RES_W-1:0] PLUS_ZERO  = RES_W'(16'h0000);
  localparam logic [RES_W-1:0] MINUS_ZERO = RES_W'(16'h8000);

  // fflags ordering {NV,DZ,OF,UF,NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
    logic [FLAG_W-1:0] fflags;
    logic              special;
  } flog_result_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // One-hot flag vector for a single exception bit.
  function automatic logic [FLAG_W-1:0] flag_bit(input int unsigned idx);
    return FLAG_W'(1) << idx;
  endfunction

  // Build a result payload from a raw bfloat16 encoding.
  function automatic flog_result_t make_result(input logic [RES_W-1:0]  bits,
                                               input logic [FLAG_W-1:0] flags,
                                               input logic              special);
    flog_result_t r;
    r.sign    = bits[RES_W-1];
    r.exp     = bits[RES_W-2 -: EXP_W];
    r.man     = bits[MAN_W-1:0];
    r.fflags  = flags;
    r.special = special;
    return r;
  endfunction

endpackage

// File: rtl/flog_result_mux.sv
// Priority encoder selecting the special-case or normal-path FLOG result.
module flog_result_mux
  import flog_pkg::*;
(
  input  logic             s_op_i,
  input  logic             is_inf_i,
  input  logic             is_nan_i,
  input  logic             is_snan_i,
  input  logic             is_zero_i,
  input  logic             s_norm_i,
  input  logic [EXP_W-1:0] exp_norm_i,
  input  logic [MAN_W-1:0] man_norm_i,
  input  logic             nx_norm_i,
  output flog_result_t     res_o
);

  // Special classes resolve in fixed priority; contradictory flags are legal.
  always_comb begin
    res_o = make_result(PLUS_ZERO, '0, 1'b0);
    if (is_snan_i) begin
      res_o = make_result(QNAN, flag_bit(FLAG_NV), 1'b1);
    end else if (is_nan_i) begin
      res_o = make_result(QNAN, '0, 1'b1);
    end else if (is_zero_i) begin
      res_o = make_result(MINUS_INF, flag_bit(FLAG_DZ), 1'b1);
    end else if (s_op_i) begin
      res_o = make_result(QNAN, flag_bit(FLAG_NV), 1'b1);
    end else if (is_inf_i) begin
      res_o = make_result(PLUS_INF, '0, 1'b1);
    end else begin
      res_o.sign    = s_norm_i;
      res_o.exp     = exp_norm_i;
      res_o.man     = man_norm_i;
      res_o.fflags  = nx_norm_i ? flag_bit(FLAG_NX) : '0;
      res_o.special = 1'b0;
    end
  end

endmodule

// File: rtl/flog_special_result_encoder.sv
// FLOG result encoder with registered valid/ready output and 2-entry skid buffer.
module flog_special_result_encoder
  import flog_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              s_op_i,
  input  logic              is_inf_i,
  input  logic              is_nan_i,
  input  logic              is_snan_i,
  input  logic              is_zero_i,
  input  logic              s_norm_i,
  input  logic [EXP_W-1:0]  exp_norm_i,
  input  logic [MAN_W-1:0]  man_norm_i,
  input  logic              nx_norm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              s_res_o,
  output logic [EXP_W-1:0]  exp_res_o,
  output logic [MAN_W-1:0]  man_res_o,
  output logic [FLAG_W-1:0] fflags_o,
  output logic              special_o,
  input  logic              clr_flags_i,
  output logic [FLAG_W-1:0] fflags_acc_o
);

  buf_state_e        state_q;
  flog_result_t      out_q;
  flog_result_t      skid_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [FLAG_W-1:0] acc_q;
  flog_result_t      mux_res;
  logic              accept;
  logic              drain;

  flog_result_mux u_mux (
    .s_op_i     (s_op_i),
    .is_inf_i   (is_inf_i),
    .is_nan_i   (is_nan_i),
    .is_snan_i  (is_snan_i),
    .is_zero_i  (is_zero_i),
    .s_norm_i   (s_norm_i),
    .exp_norm_i (exp_norm_i),
    .man_norm_i (man_norm_i),
    .nx_norm_i  (nx_norm_i),
    .res_o      (mux_res)
  );

  // Handshake qualifiers; ready comes from a flop so out_ready_i never reaches it.
  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  // Buffer control, output/skid registers and sticky flag accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      acc_q       <= '0;
    end else begin
      acc_q <= (clr_flags_i ? '0 : acc_q) | (drain ? out_q.fflags : '0);
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q       <= mux_res;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !drain) begin
            skid_q     <= mux_res;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (accept && drain) begin
            out_q <= mux_res;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign s_res_o      = out_q.sign;
  assign exp_res_o    = out_q.exp;
  assign man_res_o    = out_q.man;
  assign fflags_o     = out_q.fflags;
  assign special_o    = out_q.special;
  assign fflags_acc_o = acc_q;

endmodule
